// File: rtl/cdb_arbiter.sv
// Common-data-bus writeback arbiter: grants one requester per cycle and registers its tag/data onto the broadcast bus.
// Build option: define CDB_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      softReset,
    input  logic                      cdb_stall,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic             blocked;
    logic             anyGrant;
    logic [PTR_W-1:0] grantIdx;

    assign blocked = reset | softReset | cdb_stall;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        idx      = 0;
        cand     = '0;
        anyGrant = 1'b0;
        grantIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = PTR_W'(idx);
            if (!anyGrant && req[cand]) begin
                anyGrant = 1'b1;
                grantIdx = cand;
            end
        end
        if (blocked) begin
            anyGrant = 1'b0;
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (anyGrant) begin
            ptr <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        end
    end
`else
    always_comb begin
        anyGrant = 1'b0;
        grantIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!anyGrant && req[PTR_W'(k)]) begin
                anyGrant = 1'b1;
                grantIdx = PTR_W'(k);
            end
        end
        if (blocked) begin
            anyGrant = 1'b0;
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (anyGrant) begin
            grant[grantIdx] = 1'b1;
        end
    end

    // Tag/data hold their last value when idle; only valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= anyGrant;
            if (anyGrant) begin
                cdb_tag  <= req_tag[grantIdx*TAG_W +: TAG_W];
                cdb_data <= req_data[grantIdx*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand sequences, and randomized run against a reference model.
// Expectations follow CDB_ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_cdb_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          reset;
    logic          softReset;
    logic          cdbStall;
    logic [N-1:0]  req;
    logic [N*6-1:0]  reqTag;
    logic [N*32-1:0] reqData;
    logic [N-1:0]  grant;
    logic          cdbValid;
    logic [5:0]    cdbTag;
    logic [31:0]   cdbData;

    logic [5:0]  tags [N];
    logic [31:0] datas[N];

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(6), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .softReset(softReset), .cdb_stall(cdbStall),
        .req(req), .req_tag(reqTag), .req_data(reqData),
        .grant(grant), .cdb_valid(cdbValid), .cdb_tag(cdbTag), .cdb_data(cdbData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        reqTag  = '0;
        reqData = '0;
        for (int i = 0; i < N; i++) begin
            reqTag[i*6 +: 6]   = tags[i];
            reqData[i*32 +: 32] = datas[i];
        end
    end

    typedef struct {
        logic       rst;
        logic       srst;
        logic       stall;
        logic [3:0] rq;
        logic [3:0] gRr;
        logic [3:0] gFx;
        logic       zero;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rs, input logic srs, input logic st, input logic [3:0] rq);
        reset     = rs;
        softReset = srs;
        cdbStall  = st;
        req       = rq;
    endtask

    // One clock: grant checked mid-cycle, broadcast checked just after the edge.
    task automatic runCycle(input logic [3:0] expG, input string name);
        int          gi;
        logic [5:0]  eTag;
        logic [31:0] eData;
        gi    = -1;
        eTag  = '0;
        eData = '0;
        @(negedge clk);
        checkOutput({name, " grant"}, 32'(grant), 32'(expG));
        for (int i = 0; i < N; i++) begin
            if (expG[i]) begin
                gi    = i;
                eTag  = tags[i];
                eData = datas[i];
            end
        end
        @(posedge clk);
        #1;
        checkOutput({name, " valid"}, 32'(cdbValid), 32'(gi >= 0));
        if (gi >= 0) begin
            checkOutput({name, " tag"}, 32'(cdbTag), 32'(eTag));
            checkOutput({name, " data"}, cdbData, eData);
        end
    endtask

    // Reference selection: first requester in circular order from ptr (or from 0 for fixed priority).
    function automatic int pickModel(input logic rs, input logic srs, input logic st,
                                     input logic [3:0] rq, input int p);
        int start;
        if (rs || srs || st) return -1;
`ifdef CDB_ARB_ROUND_ROBIN_EN
        start = p;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (rq[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [3:0]  expG;
        logic [3:0]  rq;
        int          g;
        int          mPtr;
        logic        mValid;
        logic [5:0]  mTag;
        logic [31:0] mData;
        logic        rs, srs, st;

        for (int i = 0; i < N; i++) begin
            tags[i]  = 6'h10 + 6'(i);
            datas[i] = 32'hC0DE_0000 + 32'(i);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);

        // Reset then single request, with hold of tag/data once idle.
        runCycle(4'b0000, "reset");
        checkOutput("reset tag", 32'(cdbTag), 32'h0);
        checkOutput("reset data", cdbData, 32'h0);
        tags[2]  = 6'h15;
        datas[2] = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100);
        runCycle(4'b0100, "single");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        runCycle(4'b0000, "idle");
        checkOutput("idle tag hold", 32'(cdbTag), 32'h15);
        checkOutput("idle data hold", cdbData, 32'hDEADBEEF);
        tags[2]  = 6'h12;
        datas[2] = 32'hC0DE_0002;

        // Round-robin pointer is 3 here after the grant to unit 2.
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b1001, 4'b1000, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1});
        for (int r = 0; r < 8; r++) begin
            vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b1111, 4'(1 << (r % 4)), 4'b0001, 1'b0});
        end
        for (int r = 0; r < 3; r++) begin
            vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0});
        end
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0011, 4'b0010, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0011, 4'b0010, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010, 4'b0001, 1'b0});

        foreach (vecs[v]) begin
            applyStimulus(vecs[v].rst, vecs[v].srst, vecs[v].stall, vecs[v].rq);
`ifdef CDB_ARB_ROUND_ROBIN_EN
            runCycle(vecs[v].gRr, $sformatf("vec%0d", v));
`else
            runCycle(vecs[v].gFx, $sformatf("vec%0d", v));
`endif
            if (vecs[v].zero) begin
                checkOutput($sformatf("vec%0d zero tag", v), 32'(cdbTag), 32'h0);
                checkOutput($sformatf("vec%0d zero data", v), cdbData, 32'h0);
            end
        end

        // Randomized run obeying the hold-until-granted handshake.
        mPtr   = 0;
        mValid = 1'b0;
        mTag   = '0;
        mData  = '0;
        rq     = 4'b0000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rs  = (cyc == 0) || ($urandom_range(0, 39) == 0);
            srs = ($urandom_range(0, 15) == 0);
            st  = ($urandom_range(0, 4) == 0);
            applyStimulus(rs, srs, st, rq);
            g    = pickModel(rs, srs, st, rq, mPtr);
            expG = (g >= 0) ? 4'(1 << g) : 4'b0000;
            @(negedge clk);
            checkOutput("rand grant", 32'(grant), 32'(expG));
            @(posedge clk);
            if (rs) begin
                mPtr   = 0;
                mValid = 1'b0;
                mTag   = '0;
                mData  = '0;
            end else if (g >= 0) begin
                mValid = 1'b1;
                mTag   = tags[g];
                mData  = datas[g];
                mPtr   = (g + 1) % N;
            end else begin
                mValid = 1'b0;
            end
            #1;
            checkOutput("rand valid", 32'(cdbValid), 32'(mValid));
            checkOutput("rand tag", 32'(cdbTag), 32'(mTag));
            checkOutput("rand data", cdbData, mData);
            for (int i = 0; i < N; i++) begin
                if (g == i) begin
                    rq[i]    = 1'($urandom_range(0, 1));
                    tags[i]  = 6'($urandom);
                    datas[i] = $urandom;
                end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
                    rq[i]    = 1'b1;
                    tags[i]  = 6'($urandom);
                    datas[i] = $urandom;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
